// File: rtl/route_word_scheduler.sv
// rtl/route_word_scheduler.sv - round-robin burst tagger in front of the route distributor
//
// Tags each accepted word with a destination code (OUT1..OUT32) and a mode code,
// forces the data according to the mode, and walks the enabled destinations
// BURST words at a time. Mask/mode are double-buffered and only switch at a
// burst boundary so a burst never mixes two configurations.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i                schedule words; when low, finish the burst then idle
//   cfg_load_i              capture cfg_mask_i/cfg_mode_i into the shadow registers
//   cfg_mask_i, cfg_mode_i  destination enable mask, mode code
//   in_data_i/in_valid_i    input word stream, in_ready_o accepts
//   out_data_o/out_dest_o/out_mode_o/out_valid_o, out_ready_i   tagged output word
//   cfg_err_o               sticky illegal-mode flag
//   busy_o                  scheduler is in RUN
module route_word_scheduler #(
  parameter int DATA_W = 32,
  parameter int BURST  = 4,
  parameter int CNT_W  = $clog2(BURST + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              cfg_load_i,
  input  logic [31:0]       cfg_mask_i,
  input  logic [2:0]        cfg_mode_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [4:0]        out_dest_o,
  output logic [2:0]        out_mode_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              cfg_err_o,
  output logic              busy_o
);

  typedef logic [4:0] word_destination_t;

  typedef enum logic [2:0] {
    NORMAL       = 3'b000,
    ALL_SET_0    = 3'b100,
    MIDDLE_SET_0 = 3'b101,
    MIDDLE_SET_1 = 3'b110,
    ALL_SET_1    = 3'b111
  } mode_ctrl_t;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam int H = DATA_W / 2;
  localparam int Q = DATA_W / 4;
  // Ones over bits [H+Q-1:Q].
  localparam logic [DATA_W-1:0] MID_MASK = ({DATA_W{1'b1}} >> (DATA_W - H)) << Q;
  localparam logic [CNT_W-1:0]  BURST_C  = CNT_W'(BURST);

  // First set bit of m at or after start, wrapping 31 -> 0; start if none.
  function automatic word_destination_t find_from(input logic [31:0] m,
                                                  input word_destination_t start);
    word_destination_t r;
    word_destination_t idx;
    logic found;
    r = start;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      idx = start + 5'(i);
      if (!found && m[idx]) begin
        r = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] force_data(input logic [DATA_W-1:0] d,
                                                   input mode_ctrl_t m);
    case (m)
      ALL_SET_1:    force_data = {DATA_W{1'b1}};
      ALL_SET_0:    force_data = '0;
      MIDDLE_SET_1: force_data = d | MID_MASK;
      MIDDLE_SET_0: force_data = d & ~MID_MASK;
      default:      force_data = d;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [31:0]       mask_q, mask_d, sh_mask_q, sh_mask_d;
  mode_ctrl_t        mode_q, mode_d, sh_mode_q, sh_mode_d;
  logic              pending_q, pending_d;
  word_destination_t ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  word_destination_t out_dest_q, out_dest_d;
  mode_ctrl_t        out_mode_q, out_mode_d;
  logic              out_valid_q, out_valid_d;
  logic              cfg_err_q, cfg_err_d;

  logic              in_ready;
  logic              load, drain, boundary, first_apply, mode_legal;
  word_destination_t word_ptr;
  mode_ctrl_t        word_mode;
  logic [31:0]       next_mask;

  assign mode_legal = (cfg_mode_i == 3'b000) || cfg_mode_i[2];
  assign in_ready   = (state_q == S_RUN) && (cnt_q < BURST_C) && (!out_valid_q || out_ready_i);
  assign load       = in_valid_i && in_ready;
  assign drain      = out_valid_q && out_ready_i;
  // Boundary only once the last word of the burst has left the output register.
  assign boundary   = (state_q == S_RUN) && (cnt_q == BURST_C) && drain;
  // A config captured while a burst is still empty is applied as its first word enters.
  assign first_apply = (state_q == S_RUN) && (cnt_q == '0) && pending_q && load;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    mode_d      = mode_q;
    sh_mask_d   = sh_mask_q;
    sh_mode_d   = sh_mode_q;
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_dest_d  = out_dest_q;
    out_mode_d  = out_mode_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = cfg_err_q;
    word_ptr    = ptr_q;
    word_mode   = mode_q;
    next_mask   = pending_q ? sh_mask_q : mask_q;

    if (state_q == S_IDLE) begin
      if (pending_q) begin
        mask_d    = sh_mask_q;
        mode_d    = sh_mode_q;
        pending_d = 1'b0;
      end else if (enable_i && (mask_q != '0)) begin
        state_d = S_RUN;
        ptr_d   = find_from(mask_q, ptr_q);
        cnt_d   = '0;
      end
    end

    if (first_apply) begin
      mask_d    = sh_mask_q;
      mode_d    = sh_mode_q;
      pending_d = 1'b0;
      word_ptr  = find_from(sh_mask_q, ptr_q);
      word_mode = sh_mode_q;
      ptr_d     = word_ptr;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = force_data(in_data_i, word_mode);
      out_dest_d  = word_ptr;
      out_mode_d  = word_mode;
      cnt_d       = cnt_q + CNT_W'(1);
    end else if (drain) begin
      out_valid_d = 1'b0;
    end

    if (boundary) begin
      cnt_d = '0;
      if (pending_q) begin
        // New mask: search restarts at the current pointer, inclusive.
        mask_d    = sh_mask_q;
        mode_d    = sh_mode_q;
        pending_d = 1'b0;
        ptr_d     = find_from(sh_mask_q, ptr_q);
      end else begin
        ptr_d = find_from(mask_q, ptr_q + 5'd1);
      end
      if (!enable_i || (next_mask == '0)) begin
        state_d = S_IDLE;
      end
    end

    // Capture last so a load in the same cycle as an apply stays pending.
    if (cfg_load_i) begin
      sh_mask_d = cfg_mask_i;
      sh_mode_d = mode_legal ? mode_ctrl_t'(cfg_mode_i) : NORMAL;
      pending_d = 1'b1;
      if (!mode_legal) begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      mode_q      <= NORMAL;
      sh_mask_q   <= '0;
      sh_mode_q   <= NORMAL;
      pending_q   <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_dest_q  <= '0;
      out_mode_q  <= NORMAL;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      sh_mask_q   <= sh_mask_d;
      sh_mode_q   <= sh_mode_d;
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_dest_q  <= out_dest_d;
      out_mode_q  <= out_mode_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_data_o  = out_data_q;
  assign out_dest_o  = out_dest_q;
  assign out_mode_o  = out_mode_q;
  assign out_valid_o = out_valid_q;
  assign cfg_err_o   = cfg_err_q;
  assign busy_o      = (state_q == S_RUN);

endmodule
